// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, widths and opcodes for the UART/ALU sequencer
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OP_WIDTH   = 6;

  typedef enum logic [2:0] {
    ST_WAIT_A    = 3'd0,
    ST_WAIT_B    = 3'd1,
    ST_WAIT_OP   = 3'd2,
    ST_EXEC      = 3'd3,
    ST_SEND      = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // States in which a frame is being executed or transmitted.
  function automatic logic is_busy(state_t s);
    return (s == ST_EXEC) || (s == ST_SEND) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/uart_alu_ctrl_timeout_counter.sv
// rtl/uart_alu_ctrl_timeout_counter.sv - inter-byte gap counter with expiry flag
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // Count idle cycles while enabled; stop at the last value instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - collects A/B/opcode bytes, runs the ALU, sends the result
module uart_alu_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int OP_WIDTH       = DEF_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_byte,
  input  logic                  i_tx_done,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic [DATA_WIDTH-1:0] o_tx_byte,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_timeout,
  output logic                  o_drop
);

  state_t r_state;
  state_t w_next_state;
  logic   w_latch_a;
  logic   w_latch_b;
  logic   w_latch_op;
  logic   w_latch_res;
  logic   w_timeout;
  logic   w_in_wait;
  logic   w_expired;

  logic                  r_tx_start;
  logic                  r_busy;
  logic                  r_timeout;
  logic                  r_drop;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [DATA_WIDTH-1:0] r_tx_byte;

  // Only the mid-frame waits are timed; WAIT_A idles forever.
  assign w_in_wait = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (!w_in_wait || i_rx_done || w_expired),
    .i_enable (w_in_wait),
    .o_expired(w_expired)
  );

  // Next-state and latch-enable decode; an arriving byte beats a same-cycle timeout.
  always_comb begin
    w_next_state = r_state;
    w_latch_a    = 1'b0;
    w_latch_b    = 1'b0;
    w_latch_op   = 1'b0;
    w_latch_res  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_WAIT_A: begin
        if (i_rx_done) begin
          w_latch_a    = 1'b1;
          w_next_state = ST_WAIT_B;
        end
      end
      ST_WAIT_B: begin
        if (i_rx_done) begin
          w_latch_b    = 1'b1;
          w_next_state = ST_WAIT_OP;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = ST_WAIT_A;
        end
      end
      ST_WAIT_OP: begin
        if (i_rx_done) begin
          w_latch_op   = 1'b1;
          w_next_state = ST_EXEC;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_next_state = ST_WAIT_A;
        end
      end
      ST_EXEC: begin
        w_latch_res  = 1'b1;
        w_next_state = ST_SEND;
      end
      ST_SEND: begin
        w_next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_tx_done) begin
          w_next_state = ST_WAIT_A;
        end
      end
      default: begin
        w_next_state = ST_WAIT_A;
      end
    endcase
  end

  // State register plus registered operands, result and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_WAIT_A;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_byte  <= '0;
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_tx_start <= (w_next_state == ST_SEND);
      r_busy     <= is_busy(w_next_state);
      r_timeout  <= w_timeout;
      r_drop     <= i_rx_done && is_busy(r_state);
      if (w_latch_a)   r_alu_a   <= i_rx_byte;
      if (w_latch_b)   r_alu_b   <= i_rx_byte;
      if (w_latch_op)  r_alu_op  <= i_rx_byte[OP_WIDTH-1:0];
      if (w_latch_res) r_tx_byte <= i_alu_result;
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_byte  = r_tx_byte;
  assign o_tx_start = r_tx_start;
  assign o_busy     = r_busy;
  assign o_timeout  = r_timeout;
  assign o_drop     = r_drop;

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver/transmitter pair and an external combinational ALU.
- Collects three received bytes per frame: operand A, operand B, opcode. Presents them to the ALU, captures the result, and hands it to the transmitter with a one-cycle start pulse.
- Includes an inter-byte timeout so a partial frame is discarded and framing resynchronises.
- Sits at top level beside the UART, driven by the UART's rx_done/data_byte and tx_done handshakes.

Parameters:
- DATA_WIDTH, 8, width of UART bytes, ALU operands and result.
- OP_WIDTH, 6, opcode width; the low OP_WIDTH bits of the third byte are used, upper bits are ignored.
- TIMEOUT_CYCLES, 1000000, clk cycles allowed between bytes of one frame; must be ≥2.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_rx_done  in  1  one-cycle pulse: i_rx_byte is valid.
- i_rx_byte  in  DATA_WIDTH  received byte from the UART receiver.
- i_tx_done  in  1  pulse: transmitter finished the current byte.
- i_alu_result  in  DATA_WIDTH  combinational ALU result.
- o_alu_a  out  DATA_WIDTH  registered operand A.
- o_alu_b  out  DATA_WIDTH  registered operand B.
- o_alu_op  out  OP_WIDTH  registered opcode.
- o_tx_byte  out  DATA_WIDTH  byte for the transmitter; held stable from start until done.
- o_tx_start  out  1  one-cycle transmit request.
- o_busy  out  1  high in EXEC, SEND and WAIT_DONE.
- o_timeout  out  1  one-cycle pulse when a partial frame is discarded.
- o_drop  out  1  one-cycle pulse when a byte arrives while busy and is ignored.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=WAIT_A.
  - o_alu_a, o_alu_b, o_alu_op, o_tx_byte = 0.
  - o_tx_start, o_busy, o_timeout, o_drop = 0.
  - Timeout counter = 0.
  - Reset takes effect mid-frame or mid-transmit; nothing is retried after release.
- WAIT_A: on i_rx_done, latch o_alu_a <= i_rx_byte, clear the counter, go to WAIT_B.
- WAIT_B: on i_rx_done, latch o_alu_b, clear the counter, go to WAIT_OP.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 without a byte: pulse o_timeout, go to WAIT_A. o_alu_a keeps its value.
- WAIT_OP: on i_rx_done, latch o_alu_op <= i_rx_byte[OP_WIDTH-1:0], go to EXEC.
  - Timeout handled identically to WAIT_B.
  - A byte arriving on the same cycle the timeout would fire is accepted; it takes priority.
- EXEC: one cycle for the ALU to settle. Latch o_tx_byte <= i_alu_result, go to SEND.
- SEND: o_tx_start=1 for exactly this cycle, go to WAIT_DONE.
- WAIT_DONE: hold o_tx_byte. On i_tx_done go to WAIT_A.
  - No timeout in this state.
  - i_tx_done seen in any other state is ignored.
- Latency: rx_done of the opcode at edge N gives:
  - EXEC during N+1.
  - o_tx_start high during cycle N+2.
  - o_tx_byte valid from N+2.
- i_rx_done in EXEC, SEND or WAIT_DONE: byte discarded, o_drop pulses the next cycle, state unaffected.
- o_busy, o_tx_start, o_timeout and o_drop are registered (state-decoded from registered state); no combinational path from inputs.
- Counter width: $clog2(TIMEOUT_CYCLES). It saturates rather than wraps: it is cleared on leaving the wait states.

Decomposition:
- Shared package uart_pkg:
  - State encoding enum: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_DONE.
  - DATA_WIDTH and OP_WIDTH default constants.
  - Opcode localparams used by the ALU and the benches (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111).
- One sub-module, timeout_counter: clear/enable inputs, expired pulse output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Basic frame: release reset; rx bytes 0x05, 0x03, then 0x20 (ADD); ALU model returns a+b → o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'h20, o_tx_byte=0x08, o_tx_start high exactly 2 cycles after the opcode rx_done; after i_tx_done, o_busy=0 and state is WAIT_A.
- Back-to-back: second frame 0xF0, 0x0F, 0x24 (AND) sent immediately after i_tx_done → o_tx_byte=0x00, one o_tx_start pulse per frame.
- Timeout: TIMEOUT_CYCLES=16; send 0x11 only, wait 20 cycles → o_timeout pulses once at cycle 16 after the byte; then frame 0x02, 0x01, 0x22 (SUB) yields o_tx_byte=0x01.
- Drop while busy: rx byte 0xAA during WAIT_DONE → o_drop pulses, o_alu_a unchanged, next frame starts cleanly from WAIT_A.
- Async reset mid-transmit: assert reset in WAIT_DONE between clock edges → all outputs 0 immediately; after release a stale i_tx_done is ignored and a new 3-byte frame completes correctly.
- Opcode masking: third byte 0xE0 → o_alu_op=6'h20.
